data_bus_2to2_8bit: RTL and testbench
=====================================

Name: data_bus_2to2_8bit

Overview:
- Registered 2-input/2-output 8-bit bus crossbar. Routes two source buses to two destination buses, either straight through or swapped, under one select bit.
- Sits between two producer ports and two consumer ports of the datapath, e.g. to exchange operand buses ahead of an ALU or register file.
- Outputs are registered, with one cycle of latency, so the block can be placed on a timing boundary.

Parameters:
- WIDTH, 8, bit width of each data bus. The module name fixes 8; the parameter exists for reuse only.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data1  input  WIDTH  source bus 1.
- data2  input  WIDTH  source bus 2.
- select  input  1  routing control: 0 = straight, 1 = swap.
- in_valid  input  1  qualifies data1, data2 and select for capture this cycle.
- dataOut1  output  WIDTH  destination bus 1, registered.
- dataOut2  output  WIDTH  destination bus 2, registered.
- out_valid  output  1  dataOut1 and dataOut2 hold a newly captured routing result.
- swapped  output  1  registered copy of the select value used for the current outputs.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously to clk):
  - dataOut1 = 0, dataOut2 = 0.
  - out_valid = 0, swapped = 0.
  - rst has priority over every other input.
- Routing function, evaluated combinationally on the inputs:
  - select=0: next dataOut1 = data1, next dataOut2 = data2.
  - select=1: next dataOut1 = data2, next dataOut2 = data1.
  - Pure bit copy. No arithmetic, no width change, no sign handling.
- Capture: on rising clk with in_valid=1, register both routed buses, set swapped <= select and out_valid <= 1.
- Latency: outputs reflect the inputs sampled at edge N from edge N onward (1-cycle register latency). Full throughput, one new routing result per cycle.
- Hold: on rising clk with in_valid=0, dataOut1, dataOut2 and swapped keep their values; out_valid <= 0.
- data1 == data2: outputs are equal regardless of select. swapped still records select.
- Select changes with in_valid=0 have no effect on the outputs.
- Reset asserted mid-stream: outputs clear immediately (asynchronously). The first capture after release takes place at the first clk edge with rst=0 and in_valid=1.
- X on select while in_valid=1 is illegal. The verification bench flags it with an assertion.
- No backpressure: consumers must accept out_valid pulses as they occur.

Decomposition:
- Shared package data_bus_pkg:
  - constant DATA_BUS_WIDTH = 8.
  - constants SEL_STRAIGHT = 1'b0 and SEL_SWAP = 1'b1.
  - typedef data_bus_t as a DATA_BUS_WIDTH-bit logic vector.
- One sub-module, bus_mux_2to1: WIDTH-parameterised 2:1 mux, instantiated twice.
  - Instance for dataOut1 selects data1/data2.
  - Instance for dataOut2 selects data2/data1.
- Output registers, valid and swapped flags live in the top module.

Test Plan:
- Reset: assert rst with nonzero outputs held -> dataOut1=0, dataOut2=0, out_valid=0, swapped=0 immediately, without waiting for a clk edge.
- Straight: data1=8'd1, data2=8'd2, select=0, in_valid=1 -> after 1 edge dataOut1=8'd1, dataOut2=8'd2, out_valid=1, swapped=0.
- Swap: data1=8'd1, data2=8'd2, select=1, in_valid=1 -> dataOut1=8'd2, dataOut2=8'd1, swapped=1.
- Reversed inputs: data1=8'd2, data2=8'd1 with select=0 then select=1 -> first 2/1, then 1/2, on consecutive cycles (back-to-back throughput).
- Hold: after capturing 8'hA5/8'h3C, drive in_valid=0 with select toggling and data changing -> outputs unchanged, out_valid=0.
- Boundary values: data1=8'hFF, data2=8'h00, select=1 -> dataOut1=8'h00, dataOut2=8'hFF. Then pulse rst mid-stream -> outputs 0, and the next valid capture routes correctly.

Source files
------------

// File: rtl/data_bus_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
//   Shared definitions for the 2-to-2 data bus crossbar.
//   - DATA_BUS_WIDTH : width of every source/destination bus
//   - SEL_STRAIGHT   : select encoding for pass-through routing
//   - SEL_SWAP       : select encoding for crossed routing
//   - data_bus_t     : bus-wide data type
// -----------------------------------------------------------------------------
package data_bus_pkg;

  localparam int unsigned DATA_BUS_WIDTH = 8;

  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_SWAP     = 1'b1;

  typedef logic [DATA_BUS_WIDTH-1:0] data_bus_t;

endpackage : data_bus_pkg

// File: rtl/bus_mux_2to1.sv
// -----------------------------------------------------------------------------
// bus_mux_2to1
//   Combinational WIDTH-bit 2:1 multiplexer used for crossbar routing.
//   Ports:
//     in_a  (in,  WIDTH) : chosen when sel == SEL_STRAIGHT
//     in_b  (in,  WIDTH) : chosen when sel == SEL_SWAP
//     sel   (in,  1)     : routing control
//     out_y (out, WIDTH) : selected bus
// -----------------------------------------------------------------------------
module bus_mux_2to1
  import data_bus_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_BUS_WIDTH
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sel,
  output logic [WIDTH-1:0] out_y
);

  // Select between the two source buses; pure bit copy.
  always_comb begin
    out_y = in_a;
    if (sel == SEL_SWAP) begin
      out_y = in_b;
    end else begin
      out_y = in_a;
    end
  end

endmodule : bus_mux_2to1

// File: rtl/data_bus_2to2_8bit.sv
// -----------------------------------------------------------------------------
// data_bus_2to2_8bit
//   Registered 2-input / 2-output bus crossbar. Both source buses are routed
//   either straight through or swapped under one select bit, and the routed
//   result is captured into output registers when in_valid is high.
//   Ports:
//     clk       (in,  1)     : system clock, rising edge
//     rst       (in,  1)     : asynchronous active-high reset
//     data1     (in,  WIDTH) : source bus 1
//     data2     (in,  WIDTH) : source bus 2
//     select    (in,  1)     : 0 = straight, 1 = swap
//     in_valid  (in,  1)     : qualifies data1/data2/select for capture
//     dataOut1  (out, WIDTH) : destination bus 1 (registered)
//     dataOut2  (out, WIDTH) : destination bus 2 (registered)
//     out_valid (out, 1)     : outputs hold a result captured on the last edge
//     swapped   (out, 1)     : select value used for the current outputs
// -----------------------------------------------------------------------------
module data_bus_2to2_8bit
  import data_bus_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] dataOut1,
  output logic [WIDTH-1:0] dataOut2,
  output logic             out_valid,
  output logic             swapped
);

  logic [WIDTH-1:0] route1_s;
  logic [WIDTH-1:0] route2_s;

  logic [WIDTH-1:0] data_out1_r;
  logic [WIDTH-1:0] data_out2_r;
  logic             out_valid_r;
  logic             swapped_r;

  // Destination 1 takes data1 when straight, data2 when swapped.
  bus_mux_2to1 #(
    .WIDTH (WIDTH)
  ) u_mux_out1 (
    .in_a  (data1),
    .in_b  (data2),
    .sel   (select),
    .out_y (route1_s)
  );

  // Destination 2 takes data2 when straight, data1 when swapped.
  bus_mux_2to1 #(
    .WIDTH (WIDTH)
  ) u_mux_out2 (
    .in_a  (data2),
    .in_b  (data1),
    .sel   (select),
    .out_y (route2_s)
  );

  // Output registers: capture routed buses on in_valid, otherwise hold data
  // and drop out_valid so each result appears as a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out1_r <= {WIDTH{1'b0}};
      data_out2_r <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      swapped_r   <= 1'b0;
    end else if (in_valid) begin
      data_out1_r <= route1_s;
      data_out2_r <= route2_s;
      out_valid_r <= 1'b1;
      swapped_r   <= select;
    end else begin
      data_out1_r <= data_out1_r;
      data_out2_r <= data_out2_r;
      out_valid_r <= 1'b0;
      swapped_r   <= swapped_r;
    end
  end

  assign dataOut1  = data_out1_r;
  assign dataOut2  = data_out2_r;
  assign out_valid = out_valid_r;
  assign swapped   = swapped_r;

endmodule : data_bus_2to2_8bit

// File: tb/tb_data_bus_2to2_8bit.sv
// -----------------------------------------------------------------------------
// tb_data_bus_2to2_8bit
//   Directed self-checking bench for the registered 2-to-2 bus crossbar.
// -----------------------------------------------------------------------------
module tb_data_bus_2to2_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       select;
  logic       in_valid;
  logic [7:0] dataOut1;
  logic [7:0] dataOut2;
  logic       out_valid;
  logic       swapped;

  int checks;
  int failures;

  data_bus_2to2_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .data1     (data1),
    .data2     (data2),
    .select    (select),
    .in_valid  (in_valid),
    .dataOut1  (dataOut1),
    .dataOut2  (dataOut2),
    .out_valid (out_valid),
    .swapped   (swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // X on select while capturing is illegal.
  always @(posedge clk) begin
    if (!rst && in_valid === 1'b1) begin
      assert (!$isunknown(select))
      else $error("select is X/Z while in_valid=1");
    end
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (dataOut1 !== 8'h00) begin failures++; $display("FAIL reset_out1 got=%h exp=%h", dataOut1, 8'h00); end
    checks++;
    if (dataOut2 !== 8'h00) begin failures++; $display("FAIL reset_out2 got=%h exp=%h", dataOut2, 8'h00); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 1'b0); end
    checks++;
    if (swapped !== 1'b0) begin failures++; $display("FAIL reset_swapped got=%b exp=%b", swapped, 1'b0); end
    rst = 1'b0;
    // Load nonzero outputs, then hit reset between edges.
    data1 = 8'h5A; data2 = 8'hC3; select = 1'b1; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'hC3 || dataOut2 !== 8'h5A || out_valid !== 1'b1 || swapped !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload got=%h/%h v=%b s=%b exp=c3/5a v=1 s=1", dataOut1, dataOut2, out_valid, swapped);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dataOut1 !== 8'h00) begin failures++; $display("FAIL reset_async_out1 got=%h exp=%h", dataOut1, 8'h00); end
    checks++;
    if (dataOut2 !== 8'h00) begin failures++; $display("FAIL reset_async_out2 got=%h exp=%h", dataOut2, 8'h00); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid got=%b exp=%b", out_valid, 1'b0); end
    checks++;
    if (swapped !== 1'b0) begin failures++; $display("FAIL reset_async_swapped got=%b exp=%b", swapped, 1'b0); end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_straight();
    data1 = 8'd1; data2 = 8'd2; select = 1'b0; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'd1) begin failures++; $display("FAIL straight_out1 got=%h exp=%h", dataOut1, 8'd1); end
    checks++;
    if (dataOut2 !== 8'd2) begin failures++; $display("FAIL straight_out2 got=%h exp=%h", dataOut2, 8'd2); end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL straight_valid got=%b exp=%b", out_valid, 1'b1); end
    checks++;
    if (swapped !== 1'b0) begin failures++; $display("FAIL straight_swapped got=%b exp=%b", swapped, 1'b0); end
  endtask

  task automatic test_swap();
    data1 = 8'd1; data2 = 8'd2; select = 1'b1; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'd2) begin failures++; $display("FAIL swap_out1 got=%h exp=%h", dataOut1, 8'd2); end
    checks++;
    if (dataOut2 !== 8'd1) begin failures++; $display("FAIL swap_out2 got=%h exp=%h", dataOut2, 8'd1); end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL swap_valid got=%b exp=%b", out_valid, 1'b1); end
    checks++;
    if (swapped !== 1'b1) begin failures++; $display("FAIL swap_swapped got=%b exp=%b", swapped, 1'b1); end
  endtask

  task automatic test_back_to_back();
    data1 = 8'd2; data2 = 8'd1; select = 1'b0; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'd2 || dataOut2 !== 8'd1 || out_valid !== 1'b1 || swapped !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got=%h/%h v=%b s=%b exp=02/01 v=1 s=0", dataOut1, dataOut2, out_valid, swapped);
    end
    select = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'd1 || dataOut2 !== 8'd2 || out_valid !== 1'b1 || swapped !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got=%h/%h v=%b s=%b exp=01/02 v=1 s=1", dataOut1, dataOut2, out_valid, swapped);
    end
  endtask

  task automatic test_hold();
    logic [7:0] hold_d1 [3];
    logic [7:0] hold_d2 [3];
    hold_d1[0] = 8'h11; hold_d1[1] = 8'hEE; hold_d1[2] = 8'h00;
    hold_d2[0] = 8'h22; hold_d2[1] = 8'h77; hold_d2[2] = 8'hFF;
    data1 = 8'hA5; data2 = 8'h3C; select = 1'b0; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'hA5 || dataOut2 !== 8'h3C || out_valid !== 1'b1 || swapped !== 1'b0) begin
      failures++;
      $display("FAIL hold_capture got=%h/%h v=%b s=%b exp=a5/3c v=1 s=0", dataOut1, dataOut2, out_valid, swapped);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data1 = hold_d1[i];
      data2 = hold_d2[i];
      select = ~select;
      step();
      checks++;
      if (dataOut1 !== 8'hA5 || dataOut2 !== 8'h3C || out_valid !== 1'b0 || swapped !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h/%h v=%b s=%b exp=a5/3c v=0 s=0", i, dataOut1, dataOut2, out_valid, swapped);
      end
    end
  endtask

  task automatic test_equal_inputs();
    data1 = 8'h77; data2 = 8'h77; select = 1'b1; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'h77 || dataOut2 !== 8'h77 || out_valid !== 1'b1 || swapped !== 1'b1) begin
      failures++;
      $display("FAIL equal_inputs got=%h/%h v=%b s=%b exp=77/77 v=1 s=1", dataOut1, dataOut2, out_valid, swapped);
    end
  endtask

  task automatic test_boundary();
    data1 = 8'hFF; data2 = 8'h00; select = 1'b1; in_valid = 1'b1;
    step();
    checks++;
    if (dataOut1 !== 8'h00 || dataOut2 !== 8'hFF || swapped !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL boundary_swap got=%h/%h v=%b s=%b exp=00/ff v=1 s=1", dataOut1, dataOut2, out_valid, swapped);
    end
    // Reset mid-stream while in_valid stays high: reset must win.
    data1 = 8'h81; data2 = 8'h7E; select = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dataOut1 !== 8'h00 || dataOut2 !== 8'h00 || out_valid !== 1'b0 || swapped !== 1'b0) begin
      failures++;
      $display("FAIL boundary_rst_async got=%h/%h v=%b s=%b exp=00/00 v=0 s=0", dataOut1, dataOut2, out_valid, swapped);
    end
    step();
    checks++;
    if (dataOut1 !== 8'h00 || dataOut2 !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL boundary_rst_priority got=%h/%h v=%b exp=00/00 v=0", dataOut1, dataOut2, out_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (dataOut1 !== 8'h81 || dataOut2 !== 8'h7E || out_valid !== 1'b1 || swapped !== 1'b0) begin
      failures++;
      $display("FAIL boundary_after_rst got=%h/%h v=%b s=%b exp=81/7e v=1 s=0", dataOut1, dataOut2, out_valid, swapped);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || dataOut1 !== 8'h81) begin
      failures++;
      $display("FAIL boundary_idle got=%h v=%b exp=81 v=0", dataOut1, out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    data1    = 8'h00;
    data2    = 8'h00;
    select   = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_straight();
    test_swap();
    test_back_to_back();
    test_hold();
    test_equal_inputs();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_bus_2to2_8bit
